// File: rtl/alu_pkg.sv
// Shared definitions for iter_alu: opcode encodings and the control FSM states.
package alu_pkg;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_SLT  = 3'b100;
    localparam logic [2:0] OP_SLTU = 3'b101;
    localparam logic [2:0] OP_MULU = 3'b110;
    localparam logic [2:0] OP_DIVU = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_e;

endpackage

// File: rtl/alu_muldiv_core.sv
// Shared shift/accumulate datapath: shift-add multiply or restoring divide, one bit per step.
module alu_muldiv_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] quo_nxt,
    output logic [WIDTH-1:0] rem_nxt
);

    logic             div_q, div_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [WIDTH:0]   sum, shifted, diff;

    // Multiply: {rem,quo} is the product register, quo starts as the multiplier.
    // Divide: quo starts as the dividend and fills with quotient bits from the right.
    always_comb begin
        sum     = {1'b0, rem_q} + (quo_q[0] ? {1'b0, opnd_q} : '0);
        shifted = {rem_q, quo_q[WIDTH-1]};
        diff    = shifted - {1'b0, opnd_q};
        if (div_q) begin
            quo_nxt = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
            rem_nxt = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
        end else begin
            quo_nxt = {sum[0], quo_q[WIDTH-1:1]};
            rem_nxt = sum[WIDTH:1];
        end
    end

    always_comb begin
        div_d  = div_q;
        quo_d  = quo_q;
        rem_d  = rem_q;
        opnd_d = opnd_q;
        if (load) begin
            div_d  = is_div;
            rem_d  = '0;
            quo_d  = is_div ? a : b;
            opnd_d = is_div ? b : a;
        end else if (step) begin
            quo_d = quo_nxt;
            rem_d = rem_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q  <= 1'b0;
            quo_q  <= '0;
            rem_q  <= '0;
            opnd_q <= '0;
        end else begin
            div_q  <= div_d;
            quo_q  <= quo_d;
            rem_q  <= rem_d;
            opnd_q <= opnd_d;
        end
    end

endmodule

// File: rtl/iter_alu.sv
// Iterative ALU: single-cycle logic/arith ops plus WIDTH-cycle unsigned multiply and divide.
module iter_alu
    import alu_pkg::*;
#(
    parameter int WIDTH         = 32,
    parameter bit FAST_ZERO_DIV = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic             zero
);

    localparam int             CW      = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  CNT_END = CW'(WIDTH);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic             zero_q, zero_d;
    logic             core_load, core_step;
    logic [WIDTH-1:0] core_quo, core_rem;
    logic [WIDTH-1:0] alu_res;

    always_comb begin
        alu_res = '0;
        case (op)
            OP_ADD:  alu_res = a + b;
            OP_SUB:  alu_res = a - b;
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        hi_d      = hi_q;
        core_load = 1'b0;
        core_step = 1'b0;
        case (state_q)
            RUN: begin
                core_step = 1'b1;
                cnt_d     = cnt_q + 1'b1;
                // Capture the post-step value so results land on the edge entering FIN.
                if (cnt_d == CNT_END) begin
                    state_d  = FIN;
                    result_d = core_quo;
                    hi_d     = core_rem;
                end
            end
            default: begin
                if (state_q == FIN) state_d = IDLE;
                if (start) begin
                    if (op == OP_MULU || (op == OP_DIVU && !(FAST_ZERO_DIV && b == '0))) begin
                        state_d   = RUN;
                        cnt_d     = '0;
                        core_load = 1'b1;
                    end else if (op == OP_DIVU) begin
                        state_d  = FIN;
                        result_d = '1;
                        hi_d     = a;
                    end else begin
                        state_d  = FIN;
                        result_d = alu_res;
                        hi_d     = '0;
                    end
                end
            end
        endcase
        zero_d = (result_d == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            result_q <= '0;
            hi_q     <= '0;
            zero_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            hi_q     <= hi_d;
            zero_q   <= zero_d;
        end
    end

    alu_muldiv_core #(.WIDTH(WIDTH)) u_core (
        .clk     (clk),
        .rst     (rst),
        .load    (core_load),
        .step    (core_step),
        .is_div  (op == OP_DIVU),
        .a       (a),
        .b       (b),
        .quo_nxt (core_quo),
        .rem_nxt (core_rem)
    );

    assign busy   = (state_q == RUN);
    assign done   = (state_q == FIN);
    assign result = result_q;
    assign hi     = hi_q;
    assign zero   = zero_q;

endmodule

// File: tb/tb_iter_alu.sv
// Self-checking bench for iter_alu: directed vector table, random ops vs. arithmetic model, corner sequences.
module tb_iter_alu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = '0;
    logic [31:0] a = '0, b = '0;
    logic        busy, done, zero;
    logic [31:0] result, hi;

    int checks = 0;
    int errors = 0;

    iter_alu #(.WIDTH(32), .FAST_ZERO_DIV(1'b1)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .result(result), .hi(hi), .zero(zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic [31:0] h;
        int          lat;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain arithmetic on wide integers, straight from the op definitions.
    function automatic void ref_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                   output logic [31:0] r, output logic [31:0] h, output int lat);
        longint unsigned p;
        lat = 1;
        h   = '0;
        r   = '0;
        case (o)
            3'd0: r = x + y;
            3'd1: r = x - y;
            3'd2: r = x & y;
            3'd3: r = x | y;
            3'd4: r = (int'(x) < int'(y)) ? 32'd1 : 32'd0;
            3'd5: r = (x < y) ? 32'd1 : 32'd0;
            3'd6: begin
                p   = longint'(x) * longint'(y);
                r   = p[31:0];
                h   = p[63:32];
                lat = 33;
            end
            default: begin
                if (y == 0) begin
                    r = 32'hFFFF_FFFF;
                    h = x;
                end else begin
                    r   = x / y;
                    h   = x % y;
                    lat = 33;
                end
            end
        endcase
    endfunction

    // Issue one op, scramble inputs after accept, wait for done and check everything.
    task automatic run_check(input string tag, input logic [2:0] o, input logic [31:0] x,
                             input logic [31:0] y, input logic [31:0] er, input logic [31:0] eh,
                             input int elat);
        int          lat;
        logic [31:0] prev;
        bit          held_ok;
        prev = result;
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0; op = 3'($urandom); a = $urandom; b = $urandom;
        lat = 1;
        held_ok = 1'b1;
        while (!done && lat < 100) begin
            if (result !== prev || busy !== 1'b1) held_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        chk({tag, " latency"}, 64'(lat), 64'(elat));
        chk({tag, " result"}, 64'(result), 64'(er));
        chk({tag, " hi"}, 64'(hi), 64'(eh));
        chk({tag, " zero"}, 64'(zero), 64'(er == 0));
        chk({tag, " busy_at_done"}, 64'(busy), 64'(0));
        chk({tag, " hold_during_run"}, 64'(held_ok), 64'(1));
    endtask

    vec_t vecs[$];

    initial begin
        logic [31:0] er, eh;
        int          elat, ndone, d1, d2;
        logic [2:0]  ro;
        logic [31:0] ra, rb;

        vecs.push_back('{3'd0, 32'hFFFF_FFFF, 32'd1,         32'd0,         32'd0,         1});
        vecs.push_back('{3'd4, 32'hFFFF_FFFE, 32'd1,         32'd1,         32'd0,         1});
        vecs.push_back('{3'd5, 32'hFFFF_FFFE, 32'd1,         32'd0,         32'd0,         1});
        vecs.push_back('{3'd6, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFE, 32'd1,         33});
        vecs.push_back('{3'd7, 32'd100,       32'd7,         32'd14,        32'd2,         33});
        vecs.push_back('{3'd7, 32'd100,       32'd0,         32'hFFFF_FFFF, 32'd100,       1});
        vecs.push_back('{3'd1, 32'd0,         32'd1,         32'hFFFF_FFFF, 32'd0,         1});
        vecs.push_back('{3'd2, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 32'd0,         1});
        vecs.push_back('{3'd3, 32'h0F0F_0000, 32'h0000_00F0, 32'h0F0F_00F0, 32'd0,         1});
        vecs.push_back('{3'd4, 32'd1,         32'hFFFF_FFFF, 32'd0,         32'd0,         1});
        vecs.push_back('{3'd5, 32'd1,         32'hFFFF_FFFF, 32'd1,         32'd0,         1});
        vecs.push_back('{3'd6, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 33});
        vecs.push_back('{3'd7, 32'd5,         32'd10,        32'd0,         32'd5,         33});
        vecs.push_back('{3'd6, 32'd0,         32'd12345,     32'd0,         32'd0,         33});

        repeat (3) @(negedge clk);
        chk("reset busy", 64'(busy), 64'(0));
        chk("reset done", 64'(done), 64'(0));
        chk("reset result", 64'(result), 64'(0));
        chk("reset hi", 64'(hi), 64'(0));
        chk("reset zero", 64'(zero), 64'(1));
        rst = 1'b0;

        foreach (vecs[i])
            run_check($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                      vecs[i].r, vecs[i].h, vecs[i].lat);

        for (int i = 0; i < 30; i++) begin
            ro = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom >> $urandom_range(0, 31);
            ref_op(ro, ra, rb, er, eh, elat);
            run_check($sformatf("rnd%0d op%0d", i, ro), ro, ra, rb, er, eh, elat);
        end

        // Reset in the middle of a multiply discards it.
        @(negedge clk);
        start = 1'b1; op = 3'd6; a = 32'h1234_5678; b = 32'h9ABC_DEF0;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        chk("midrun busy_before_rst", 64'(busy), 64'(1));
        rst = 1'b1;
        #1;
        chk("midrun rst busy", 64'(busy), 64'(0));
        chk("midrun rst done", 64'(done), 64'(0));
        chk("midrun rst result", 64'(result), 64'(0));
        chk("midrun rst hi", 64'(hi), 64'(0));
        chk("midrun rst zero", 64'(zero), 64'(1));
        @(negedge clk);
        rst = 1'b0;
        run_check("add_after_rst", 3'd0, 32'd3, 32'd4, 32'd7, 32'd0, 1);

        // start held through a multiply: re-accepted only in FIN, so two done pulses.
        @(negedge clk);
        start = 1'b1; op = 3'd6; a = 32'd3; b = 32'd5;
        ndone = 0; d1 = -1; d2 = -1;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (c == 34) start = 1'b0;
            if (done) begin
                ndone++;
                if (ndone == 1) d1 = c;
                if (ndone == 2) begin
                    d2 = c;
                    chk("b2b second result", 64'(result), 64'd15);
                end
            end
        end
        chk("b2b done count", 64'(ndone), 64'd2);
        chk("b2b first done cycle", 64'(d1), 64'd33);
        chk("b2b second done cycle", 64'(d2), 64'd66);

        // Back-to-back single-cycle ops: done on consecutive cycles.
        @(negedge clk);
        start = 1'b1; op = 3'd0; a = 32'd10; b = 32'd20;
        @(negedge clk);
        op = 3'd1; a = 32'd10; b = 32'd20;
        chk("b2b1 done", 64'(done), 64'd1);
        chk("b2b1 result", 64'(result), 64'd30);
        @(negedge clk);
        start = 1'b0;
        chk("b2b2 done", 64'(done), 64'd1);
        chk("b2b2 result", 64'(result), 64'hFFFF_FFF6);
        @(negedge clk);
        chk("b2b idle done", 64'(done), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
